filter_uart_tx: RTL and testbench

Serial output stage for the mixed IIR filter. It captures one low-pass/high-pass sample pair on a strobe, frames it as a 5-byte packet, and transmits it on a UART 8N1 line. A host or bench receiver reassembles the stream, the hardware counterpart of the simulation sample dump. It sits after the filter top and is the only consumer of `low_pass` and `high_pass` in the board build.

---
 rtl/filter_uart_tx_if.sv | 27 ++
 rtl/filter_uart_tx.sv | 134 +++++++++++++
 tb/tb_filter_uart_tx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/filter_uart_tx_if.sv
// Sample-pair handshake and UART status bundle for the filter serial output stage.
interface filter_uart_tx_if;
  logic        sample_valid;
  logic [15:0] low_pass;
  logic [15:0] high_pass;
  logic        tx;
  logic        busy;
  logic        dropped;

  modport master (
    output sample_valid,
    output low_pass,
    output high_pass,
    input  tx,
    input  busy,
    input  dropped
  );

  modport slave (
    input  sample_valid,
    input  low_pass,
    input  high_pass,
    output tx,
    output busy,
    output dropped
  );
endinterface

// File: rtl/filter_uart_tx.sv
// Captures a low-pass/high-pass sample pair and sends it as a 5-byte 8N1 packet:
// SYNC_BYTE, low_pass[15:8], low_pass[7:0], high_pass[15:8], high_pass[7:0].
//
// state | meaning
// IDLE  | line high, waiting for a strobe
// START | start bit (0) for one bit period
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (1), then next byte or back to IDLE
module filter_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input logic            clk,
  input logic            rst,
  filter_uart_tx_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [1:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [2:0]  byte_idx;
  logic [7:0]  shift;
  logic [31:0] hold;
  logic        tx_r;
  logic        dropped_r;
  logic        baud_done;
  logic [7:0]  next_byte;

  assign baud_done   = (baud_cnt == BAUD_LAST);
  assign bus.tx      = tx_r;
  assign bus.busy    = (state != IDLE);
  assign bus.dropped = dropped_r;

  // Byte following the current one; byte_idx 0 is the sync byte.
  always_comb begin
    next_byte = hold[7:0];
    case (byte_idx)
      3'd0:    next_byte = hold[31:24];
      3'd1:    next_byte = hold[23:16];
      3'd2:    next_byte = hold[15:8];
      default: next_byte = hold[7:0];
    endcase
  end

  // Packet framing FSM; tx is registered and set on each bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shift    <= '0;
      hold     <= '0;
      tx_r     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_r <= 1'b1;
          if (bus.sample_valid) begin
            hold     <= {bus.low_pass, bus.high_pass};
            shift    <= SYNC_BYTE;
            byte_idx <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            tx_r     <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx_r     <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              tx_r    <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx_r    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (byte_idx == 3'd4) begin
              tx_r  <= 1'b1;
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              shift    <= next_byte;
              tx_r     <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          tx_r  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag: a strobe while a packet is in flight; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      dropped_r <= 1'b0;
    end else if (bus.sample_valid && (state != IDLE)) begin
      dropped_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_filter_uart_tx.sv
// Directed bench for filter_uart_tx with CLKS_PER_BIT=4 and a bit-centre UART receiver.
module tb_filter_uart_tx;

  localparam int CPB = 4;
  localparam int PKT_CYC = 50 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  filter_uart_tx_if bus ();

  filter_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the observation point of cycle A+1. Returns at cycle A+201
  // (or at A+91 when a mid-packet reset is injected).
  task automatic run_packet(input string tag, input logic [31:0] exp_data,
                            input bit scramble, input bit inject_drops, input bit inject_rst);
    logic [49:0] bits;
    logic [39:0] dec;
    bit          busy_ok;
    bit          frame_ok;
    bits    = '0;
    busy_ok = 1'b1;
    chk({tag, "_start_at_A1"}, 64'(bus.tx), 64'd0);
    for (int t = 1; t <= PKT_CYC; t++) begin
      if (t > 1) tick();
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (((t - 1) % CPB) == 1) bits[(t - 1) / CPB] = bus.tx;
      if (scramble) begin
        bus.low_pass  = 16'($urandom);
        bus.high_pass = 16'($urandom);
      end
      if (inject_drops) begin
        bus.sample_valid = (t == 50) || (t == PKT_CYC);
        if (t == 51) chk({tag, "_dropped_A51"}, 64'(bus.dropped), 64'd1);
      end
      if (inject_rst) begin
        if (t == 90) rst = 1'b1;
        if (t == 91) begin
          rst = 1'b0;
          chk({tag, "_rst_tx"}, 64'(bus.tx), 64'd1);
          chk({tag, "_rst_busy"}, 64'(bus.busy), 64'd0);
          return;
        end
      end
    end
    tick();
    bus.sample_valid = 1'b0;
    chk({tag, "_busy_200"}, 64'(busy_ok), 64'd1);
    chk({tag, "_busy_A201"}, 64'(bus.busy), 64'd0);
    chk({tag, "_tx_A201"}, 64'(bus.tx), 64'd1);
    frame_ok = 1'b1;
    for (int b = 0; b < 5; b++) begin
      if (bits[10 * b] !== 1'b0 || bits[10 * b + 9] !== 1'b1) frame_ok = 1'b0;
      dec[39 - 8 * b -: 8] = bits[10 * b + 1 +: 8];
    end
    chk({tag, "_framing"}, 64'(frame_ok), 64'd1);
    chk({tag, "_payload"}, 64'(dec), 64'({8'hA5, exp_data}));
  endtask

  task automatic strobe(input logic [15:0] lp, input logic [15:0] hp);
    bus.low_pass     = lp;
    bus.high_pass    = hp;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.low_pass     = '0;
    bus.high_pass    = '0;

    // Reset for 3 cycles, with a strobe overlapping it (reset has priority).
    rst = 1'b1;
    tick();
    bus.sample_valid = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.sample_valid = 1'b0;
    chk("reset_tx", 64'(bus.tx), 64'd1);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_dropped", 64'(bus.dropped), 64'd0);
    repeat (5) tick();
    chk("idle_tx", 64'(bus.tx), 64'd1);
    chk("idle_busy", 64'(bus.busy), 64'd0);

    // Single packet.
    strobe(16'h1234, 16'hFEDC);
    run_packet("single", 32'h1234FEDC, 1'b0, 1'b0, 1'b0);
    chk("single_dropped", 64'(bus.dropped), 64'd0);
    repeat (3) tick();

    // Inputs change every cycle after acceptance.
    strobe(16'hBEEF, 16'h0F1E);
    run_packet("hold", 32'hBEEF0F1E, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();

    // Drops at A+50 and at the final stop cycle A+200.
    strobe(16'h00FF, 16'hFF00);
    run_packet("drop", 32'h00FFFF00, 1'b0, 1'b1, 1'b0);
    chk("drop_sticky", 64'(bus.dropped), 64'd1);
    repeat (6) tick();
    chk("drop_one_pkt_busy", 64'(bus.busy), 64'd0);
    chk("drop_one_pkt_tx", 64'(bus.tx), 64'd1);

    // Reset with a concurrent strobe clears dropped and accepts nothing.
    rst = 1'b1;
    bus.sample_valid = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.sample_valid = 1'b0;
    chk("rstprio_dropped", 64'(bus.dropped), 64'd0);
    chk("rstprio_busy", 64'(bus.busy), 64'd0);
    repeat (3) tick();

    // Back-to-back: second strobe at A+201.
    strobe(16'h1234, 16'hFEDC);
    run_packet("b2b_first", 32'h1234FEDC, 1'b0, 1'b0, 1'b0);
    strobe(16'h8000, 16'h7FFF);
    run_packet("b2b_second", 32'h80007FFF, 1'b0, 1'b0, 1'b0);
    chk("b2b_dropped", 64'(bus.dropped), 64'd0);
    repeat (3) tick();

    // Mid-packet reset at A+90, new strobe at A+95.
    strobe(16'hAAAA, 16'h5555);
    run_packet("midrst", 32'hAAAA5555, 1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    chk("midrst_idle_tx", 64'(bus.tx), 64'd1);
    strobe(16'hC3A5, 16'h0001);
    run_packet("after_rst", 32'hC3A50001, 1'b0, 1'b0, 1'b0);
    chk("after_rst_dropped", 64'(bus.dropped), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
